// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request record.
// Pure declarations: no latency, no backpressure.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int REG_DATA_W = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side and register-file-side signals of the write-port arbiter.
// master = requesters plus register file (drive requests/stall), slave = arbiter.
interface regfile_wr_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 32
);
   logic [NREQ-1:0]                         req_valid;
   logic [regfile_pkg::REG_ADDR_W*NREQ-1:0] req_addr;
   logic [DATA_W*NREQ-1:0]                  req_data;
   logic [NREQ-1:0]                         req_ready;
   logic                                    wr_stall;
   logic                                    wr_valid;
   logic [regfile_pkg::REG_ADDR_W-1:0]      wr_addr;
   logic [regfile_pkg::NUM_REGS-1:0]        wr_sel;
   logic [DATA_W-1:0]                       wr_data;

   modport master (
      output req_valid, req_addr, req_data, wr_stall,
      input  req_ready, wr_valid, wr_addr, wr_sel, wr_data
   );

   modport slave (
      input  req_valid, req_addr, req_data, wr_stall,
      output req_ready, wr_valid, wr_addr, wr_sel, wr_data
   );
endinterface

// File: rtl/onehot_dec5.sv
// 5-to-32 one-hot decoder; combinational, no backpressure.
// A disabled decoder drives all zeros rather than selecting register 0.
module onehot_dec5
   import regfile_pkg::*;
(
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] addr,
   output logic [NUM_REGS-1:0]   sel
);
   assign sel = en ? (NUM_REGS'(1) << addr) : '0;
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin register-file write-port arbiter; 1-cycle latency, wr_stall with a valid write freezes the port and zeroes req_ready.
// REGFILE_ZERO_GUARD_EN: accepted writes to register 0 are dropped (never presented).
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_wr_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NREQ);
   localparam int SUM_W = PTR_W + 1;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } req_t;

   req_t             reqs [NREQ];
   req_t             wr_q;
   logic             wr_valid_q;
   logic [PTR_W-1:0] rr_ptr;
   logic             hold;
   logic             gnt_vld;
   logic [PTR_W-1:0] gnt_idx;
   logic [SUM_W-1:0] sum;
   logic [NUM_REGS-1:0] sel;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign reqs[i] = '{addr: bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W],
                         data: bus.req_data[i*DATA_W +: DATA_W]};
   end

   assign hold = wr_valid_q & bus.wr_stall;

   // Scan from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
         if (!gnt_vld && bus.req_valid[sum[PTR_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = sum[PTR_W-1:0];
         end
      end
   end

   assign bus.req_ready = (rst_n && !hold && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         wr_valid_q <= 1'b0;
         wr_q       <= '0;
      end else if (!hold) begin
         if (gnt_vld) begin
            wr_q       <= reqs[gnt_idx];
`ifdef REGFILE_ZERO_GUARD_EN
            wr_valid_q <= (reqs[gnt_idx].addr != '0);
`else
            wr_valid_q <= 1'b1;
`endif
            rr_ptr     <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         end else begin
            wr_valid_q <= 1'b0;
         end
      end
   end

   onehot_dec5 u_dec (
      .en   (wr_valid_q),
      .addr (wr_q.addr),
      .sel  (sel)
   );

   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_q.addr;
   assign bus.wr_data  = wr_q.data;
   assign bus.wr_sel   = sel;
endmodule
